// File: rtl/fifo256_to_pipe32.sv
// Drains 256-bit words from the ADC packing FIFO and serializes them LSB-first
// into 32-bit host pipe words, with a two-deep word buffer for gap-free reads.
module fifo256_to_pipe32 #(
    parameter int OUT_W      = 32,
    parameter int BLK_THRESH = 8
) (
    input  logic             p0_rd_clk,
    input  logic             rst,
    input  logic             p0_empty,
    input  logic             p0_valid,
    input  logic [5:0]       p0_rd_data_cnt,
    input  logic [255:0]     p0_data_i,
    output logic             p0_rd_en,
    input  logic             pipe_rd,
    output logic [OUT_W-1:0] pipe_dout,
    output logic             pipe_blk_rdy,
    output logic [31:0]      word_cnt,
    output logic             underrun
);

    localparam int            SLICES   = 256 / OUT_W;
    localparam int            IDX_W    = $clog2(SLICES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);
    localparam logic [6:0]    THRESH   = 7'(BLK_THRESH);

    logic [255:0]     cur_buf;
    logic [255:0]     nxt_buf;
    logic             cur_vld;
    logic             nxt_vld;
    logic             fetch_pend;
    logic [IDX_W-1:0] idx;

    logic drain;
    logic drain_last;
    logic load;
    logic cur_free;
    logic load_cur;
    logic load_nxt;

    // Words held here plus words still in the FIFO; 7 bits so the sum cannot wrap.
    function automatic logic [6:0] occupancy(input logic [5:0] fifo_cnt,
                                             input logic       a,
                                             input logic       b,
                                             input logic       c);
        return {1'b0, fifo_cnt} + {6'd0, a} + {6'd0, b} + {6'd0, c};
    endfunction

    assign p0_rd_en = !rst && !p0_empty && !fetch_pend && !(cur_vld && nxt_vld);

    assign drain      = pipe_rd && cur_vld;
    assign drain_last = drain && (idx == IDX_LAST);
    assign load       = p0_valid && fetch_pend;

    // A returning word may go straight into cur when cur empties on this very edge.
    assign cur_free = !cur_vld || (drain_last && !nxt_vld);
    assign load_cur = load && cur_free;
    assign load_nxt = load && !cur_free;

    assign pipe_dout = cur_buf[idx*OUT_W +: OUT_W];

    always_ff @(posedge p0_rd_clk) begin
        if (rst) begin
            cur_buf      <= '0;
            cur_vld      <= 1'b0;
            nxt_vld      <= 1'b0;
            fetch_pend   <= 1'b0;
            idx          <= '0;
            word_cnt     <= '0;
            underrun     <= 1'b0;
            pipe_blk_rdy <= 1'b0;
        end else begin
            if (p0_rd_en) begin
                fetch_pend <= 1'b1;
            end else if (load) begin
                fetch_pend <= 1'b0;
            end

            if (pipe_rd && !cur_vld) begin
                underrun <= 1'b1;
            end

            if (drain) begin
                word_cnt <= word_cnt + 32'd1;
                if (idx != IDX_LAST) begin
                    idx <= idx + 1'b1;
                end else if (nxt_vld) begin
                    cur_buf <= nxt_buf;
                    idx     <= '0;
                    nxt_vld <= 1'b0;
                end else begin
                    cur_vld <= 1'b0;
                end
            end

            // Later assignments win over the drain updates above.
            if (load_cur) begin
                cur_buf <= p0_data_i;
                cur_vld <= 1'b1;
                idx     <= '0;
            end
            if (load_nxt) begin
                nxt_buf <= p0_data_i;
                nxt_vld <= 1'b1;
            end

            pipe_blk_rdy <= occupancy(p0_rd_data_cnt, cur_vld, nxt_vld, fetch_pend) >= THRESH;
        end
    end

endmodule
